// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction RAM read port, redirect request and
// decoder-facing instruction handshake.
interface fetch_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned MEM_W  = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [MEM_W-1:0]  mem_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [MEM_W-1:0]  instr;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output mem_addr, mem_read, mem_write,
    input  mem_data,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_addr, mem_read, mem_write,
    output mem_data,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC, 1-cycle RAM reads, prefetch FIFO
// toward the decoder, flush-and-restart on redirect.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       MEM_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       DEPTH    = 4
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [MEM_W-1:0]  fifo_word [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              issue;
  logic              push;
  logic              pop;

  // Issue only while FIFO space covers every word already requested.
  always_comb begin
    issue = !rst && !bus.redirect_valid &&
            ((count + CNT_W'(inflight)) < CNT_W'(DEPTH));
    push  = inflight && !bus.redirect_valid;
    pop   = bus.instr_valid && bus.instr_ready;
  end

  assign bus.mem_addr    = fetch_pc;
  assign bus.mem_read    = issue;
  assign bus.mem_write   = 1'b0;
  assign bus.instr_valid = !rst && (count != '0);
  assign bus.instr       = fifo_word[rd_ptr];
  assign bus.instr_pc    = fifo_pc[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_word[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (bus.redirect_valid) begin
      // Flush dominates: returning data and any pop this cycle are dropped.
      fetch_pc <= bus.redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_W'(1);
      end
      if (push) begin
        fifo_word[wr_ptr] <= bus.mem_data;
        fifo_pc[wr_ptr]   <= inflight_pc;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a behavioural 1-cycle RAM.
`timescale 1ns/1ps
module tb_fetch_unit;
  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   mw_bad   = 0;

  fetch_if #(.ADDR_W(16), .MEM_W(16)) bus ();

  fetch_unit #(.ADDR_W(16), .MEM_W(16), .RESET_PC(16'h0000), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] ram_val(input logic [15:0] a);
    if (a < 16'd4) return (a + 16'd1) * 16'h1111;
    return a ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_read) bus.mem_data <= ram_val(bus.mem_addr);
  end

  always @(negedge clk) begin
    if (bus.mem_write !== 1'b0) mw_bad++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rv;
    logic [15:0] rpc;
    logic        rdy;
    logic        e_read;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rv, input logic [15:0] rpc,
                              input logic rdy, input logic er, input logic [15:0] ea,
                              input logic ev, input logic [15:0] ep);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_read = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    logic [15:0] wrap_exp [4];
    logic [15:0] exp_pc;
    logic [15:0] next_addr;
    int          outstanding;
    int          delivered;
    int          got;

    // Free-running from reset release.
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0001, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0002, 1, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0003, 1, 16'h0001));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0004, 1, 16'h0002));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0005, 1, 16'h0003));
    // Reset mid-stream, then stall with instr_ready=0 until the FIFO fills.
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0006, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0001, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0002, 1, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0003, 1, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0004, 1, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0004, 1, 16'h0000));
    // Drain.
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0004, 1, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0004, 1, 16'h0001));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0005, 1, 16'h0002));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0006, 1, 16'h0003));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0007, 1, 16'h0004));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0008, 1, 16'h0005));
    // Fill to 3 entries with a read in flight, then redirect to 0x0040.
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0009, 1, 16'h0006));
    vecs.push_back(mk(0, 1, 16'h0040, 1, 0, 16'h000A, 1, 16'h0006));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0040, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0041, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0042, 1, 16'h0040));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0043, 1, 16'h0041));
    // Back-to-back redirects: the second target wins.
    vecs.push_back(mk(0, 1, 16'h0200, 1, 0, 16'h0044, 1, 16'h0042));
    vecs.push_back(mk(0, 1, 16'h0300, 1, 0, 16'h0200, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0300, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0301, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0302, 1, 16'h0300));

    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      rst                = vecs[i].rst;
      bus.redirect_valid = vecs[i].rv;
      bus.redirect_pc    = vecs[i].rpc;
      bus.instr_ready    = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("row%0d_mem_read", i),    32'(bus.mem_read),    32'(vecs[i].e_read));
      chk($sformatf("row%0d_mem_addr", i),    32'(bus.mem_addr),    32'(vecs[i].e_addr));
      chk($sformatf("row%0d_instr_valid", i), 32'(bus.instr_valid), 32'(vecs[i].e_valid));
      chk($sformatf("row%0d_mem_write", i),   32'(bus.mem_write),   32'(0));
      if (vecs[i].e_valid) begin
        chk($sformatf("row%0d_instr_pc", i), 32'(bus.instr_pc), 32'(vecs[i].e_pc));
        chk($sformatf("row%0d_instr", i),    32'(bus.instr),    32'(ram_val(vecs[i].e_pc)));
      end
      @(posedge clk);
      #1;
    end

    // Redirect near the top of memory: PC must wrap to 0.
    wrap_exp[0] = 16'hFFFE; wrap_exp[1] = 16'hFFFF;
    wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0001;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'hFFFE;
    bus.instr_ready    = 1'b1;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 12 && got < 4; c++) begin
      @(negedge clk);
      if (bus.instr_valid) begin
        chk($sformatf("wrap_pc%0d", got), 32'(bus.instr_pc), 32'(wrap_exp[got]));
        chk($sformatf("wrap_instr%0d", got), 32'(bus.instr), 32'(ram_val(wrap_exp[got])));
        got++;
      end
      @(posedge clk); #1;
    end
    chk("wrap_delivered", 32'(got), 32'(4));

    // Random back-pressure with an occupancy model of the issue rule.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0100;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    exp_pc = 16'h0100; next_addr = 16'h0100; outstanding = 0; delivered = 0;
    for (int c = 0; c < 200; c++) begin
      bus.instr_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rand_issue_rule", 32'(bus.mem_read), 32'(outstanding < 4));
      if (bus.mem_read) begin
        chk("rand_mem_addr", 32'(bus.mem_addr), 32'(next_addr));
        next_addr = next_addr + 16'd1;
        outstanding++;
      end
      if (bus.instr_valid && bus.instr_ready) begin
        chk("rand_instr_pc", 32'(bus.instr_pc), 32'(exp_pc));
        chk("rand_instr",    32'(bus.instr),    32'(ram_val(exp_pc)));
        exp_pc = exp_pc + 16'd1;
        outstanding--;
        delivered++;
      end
      @(posedge clk); #1;
    end
    chk("rand_throughput", 32'(delivered >= 60), 32'(1));

    // One-cycle reset with a read in flight.
    bus.instr_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_mem_read", 32'(bus.mem_read), 32'(0));
    chk("midrst_valid",    32'(bus.instr_valid), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_c0_read",  32'(bus.mem_read),    32'(1));
    chk("postrst_c0_addr",  32'(bus.mem_addr),    32'(0));
    chk("postrst_c0_valid", 32'(bus.instr_valid), 32'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("postrst_c1_addr",  32'(bus.mem_addr),    32'(1));
    chk("postrst_c1_valid", 32'(bus.instr_valid), 32'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("postrst_c2_valid", 32'(bus.instr_valid), 32'(1));
    chk("postrst_c2_pc",    32'(bus.instr_pc),    32'(0));
    chk("postrst_c2_instr", 32'(bus.instr),       32'(16'h1111));
    @(posedge clk); #1;

    chk("mem_write_never_set", 32'(mw_bad), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
